// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, per-stage stall/flush, divider latency
// counter and exception redirect latch. Define HAZARD_BRANCH_FWD_EN for D-stage branch forwarding.
module hazard_ctrl #(
  parameter int          RA_W       = 5,
  parameter int          DIV_CYCLES = 34,
  parameter logic [31:0] EXC_VEC    = 32'hBFC00380
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_stall,
  input  logic            d_stall,
  input  logic [RA_W-1:0] rsD,
  input  logic [RA_W-1:0] rtD,
  input  logic            branchD,
  input  logic [RA_W-1:0] rsE,
  input  logic [RA_W-1:0] rtE,
  input  logic [RA_W-1:0] writeregE,
  input  logic            regwriteE,
  input  logic            memtoregE,
  input  logic            div_startE,
  input  logic [RA_W-1:0] writeregM,
  input  logic            regwriteM,
  input  logic            memtoregM,
  input  logic [RA_W-1:0] writeregW,
  input  logic            regwriteW,
  input  logic [31:0]     excepttypeW,
  input  logic [31:0]     cp0_epcW,
  output logic [1:0]      forwardaD,
  output logic [1:0]      forwardbD,
  output logic [1:0]      forwardaE,
  output logic [1:0]      forwardbE,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            stallM,
  output logic            stallW,
  output logic            flushF,
  output logic            flushD,
  output logic            flushE,
  output logic            flushM,
  output logic            flushW,
  output logic            div_busyE,
  output logic            div_doneE,
  output logic            redirect,
  output logic [31:0]     newpc
);

  localparam int               CNT_W     = $clog2(DIV_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [31:0]      ERET_CODE = 32'h0000000E;

  function automatic logic regMatch(input logic [RA_W-1:0] src,
                                    input logic [RA_W-1:0] dst,
                                    input logic            we);
    return (src != '0) && (src == dst) && we;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [31:0]      pc_q, pc_d;

  logic        matchRsDE, matchRtDE, matchRsDM, matchRtDM;
  logic        lwstall, brstall, memwait, divBusy, exc;
  logic [31:0] excTarget;

  assign matchRsDE = regMatch(rsD, writeregE, regwriteE);
  assign matchRtDE = regMatch(rtD, writeregE, regwriteE);
  assign matchRsDM = regMatch(rsD, writeregM, regwriteM);
  assign matchRtDM = regMatch(rtD, writeregM, regwriteM);

  assign lwstall   = memtoregE & (matchRsDE | matchRtDE);
  assign divBusy   = div_startE | (cnt_q != '0);
  assign memwait   = d_stall | divBusy;
  assign exc       = (excepttypeW != '0);
  assign excTarget = (excepttypeW == ERET_CODE) ? cp0_epcW : EXC_VEC;

  always_comb begin
    forwardaE = 2'b00;
    forwardbE = 2'b00;
    if (regMatch(rsE, writeregM, regwriteM))      forwardaE = 2'b10;
    else if (regMatch(rsE, writeregW, regwriteW)) forwardaE = 2'b01;
    if (regMatch(rtE, writeregM, regwriteM))      forwardbE = 2'b10;
    else if (regMatch(rtE, writeregW, regwriteW)) forwardbE = 2'b01;
  end

`ifdef HAZARD_BRANCH_FWD_EN
  // Branch operands come straight from E/M results unless they are still loads in flight.
  always_comb begin
    forwardaD = 2'b00;
    forwardbD = 2'b00;
    if (matchRsDE && !memtoregE)      forwardaD = 2'b10;
    else if (matchRsDM && !memtoregM) forwardaD = 2'b01;
    if (matchRtDE && !memtoregE)      forwardbD = 2'b10;
    else if (matchRtDM && !memtoregM) forwardbD = 2'b01;
  end

  assign brstall = branchD & memtoregM & (matchRsDM | matchRtDM);
`else
  logic unusedMemtoregM;

  assign unusedMemtoregM = memtoregM;
  assign forwardaD       = 2'b00;
  assign forwardbD       = 2'b00;
  assign brstall         = branchD & (matchRsDE | matchRtDE | matchRsDM | matchRtDM);
`endif

  // An exception aborts any divide in progress; starts while busy are ignored.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    pc_d   = pc_q;
    if (exc)                    cnt_d = '0;
    else if (cnt_q != '0)       cnt_d = cnt_q - CNT_ONE;
    else if (div_startE)        cnt_d = DIV_LOAD;
    if (exc && i_stall) begin
      pend_d = 1'b1;
      pc_d   = excTarget;
    end else if (!i_stall) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      pc_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      pc_q   <= pc_d;
    end
  end

  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    stallW    = 1'b0;
    flushF    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    flushW    = 1'b0;
    div_busyE = 1'b0;
    div_doneE = 1'b0;
    redirect  = 1'b0;
    newpc     = '0;
    if (rst) begin
      flushF = 1'b1;
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else begin
      div_busyE = divBusy;
      div_doneE = (cnt_q == CNT_ONE);
      redirect  = exc | pend_q;
      if (exc) begin
        newpc  = excTarget;
        flushF = 1'b1;
        flushD = 1'b1;
        flushE = 1'b1;
        flushM = 1'b1;
        flushW = 1'b1;
      end else if (pend_q) begin
        newpc  = pc_q;
        flushD = 1'b1;
        stallF = i_stall;
      end else begin
        stallF = i_stall | lwstall | brstall | memwait;
        stallD = i_stall | lwstall | brstall | memwait;
        flushE = (lwstall | brstall) & ~memwait;
        stallE = memwait | i_stall;
        stallM = memwait;
        flushW = memwait;
      end
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core; successor to the single-cycle combinational hazard unit. It generates forwarding selects for the D and E stages and per-stage stall/flush. It also owns three pieces of state: a divider-latency counter, which replaces the external divider stall, an exception redirect latch that holds a PC redirect across instruction-SRAM wait cycles, and data-SRAM wait bubbling. It sits beside the datapath and drives every pipeline-register enable and clear.

## Interface
Parameters:
- RA_W, 5, register-address width
- DIV_CYCLES, 34, divider latency in cycles (≥2)
- EXC_VEC, 32'hBFC00380, general exception entry

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_stall  in  1  instruction SRAM not ready this cycle
- d_stall  in  1  data SRAM not ready this cycle
- rsD, rtD  in  RA_W  D-stage source registers
- branchD  in  1  branch in D
- rsE, rtE, writeregE  in  RA_W  E-stage sources/destination
- regwriteE, memtoregE  in  1  E write-enable / load
- div_startE  in  1  div/divu in E, first cycle
- writeregM  in  RA_W; regwriteM, memtoregM  in  1
- writeregW  in  RA_W; regwriteW  in  1
- excepttypeW, cp0_epcW  in  32  exception code / EPC at W
- forwardaD, forwardbD  out  2  00 regfile, 10 E result, 01 M result
- forwardaE, forwardbE  out  2  00 regfile, 10 M, 01 W
- stallF, stallD, stallE, stallM, stallW  out  1
- flushF, flushD, flushE, flushM, flushW  out  1
- div_busyE  out  1  divider counting
- div_doneE  out  1  one-cycle pulse, quotient valid
- redirect  out  1  PC must load newpc
- newpc  out  32  redirect target

## Operation
- Match rule: the source register is ≠0, it equals the destination register, and that stage's regwrite is set.
- E forwarding: M match → 10; else W match → 01; else 00. Applies to rsE and rtE independently.
- lwstall = memtoregE & match(writeregE, rsD|rtD).
- brstall: see Configuration.
- Divider counter `cnt` (width ceil(log2(DIV_CYCLES))+1):
  - div_startE while cnt==0 loads DIV_CYCLES-1.
  - cnt decrements while nonzero.
  - div_busyE = div_startE | (cnt≠0).
  - div_doneE = (cnt==1).
  - div_startE while busy is ignored.
- Exception: exc = excepttypeW≠0.
  - Target: excepttypeW==32'h0000000E (eret) → cp0_epcW; any other nonzero code → EXC_VEC.
  - If exc & i_stall: set `pend` and capture the target into `pc_q`.
  - `pend` clears on the first cycle with i_stall=0.
  - redirect = exc | pend.
  - newpc = target when exc, pc_q when pend & !exc, else 0.
- Stall/flush equations, evaluated in priority order:
  - exc: all flushF..W=1, all stalls=0, cnt←0.
  - pend & !exc: flushD=1, stallF=i_stall, other stalls 0.
  - Otherwise:
    - memwait = d_stall | div_busyE.
    - stallF = i_stall | lwstall | brstall | memwait.
    - stallD = stallF.
    - flushE = (lwstall|brstall) & !memwait.
    - stallE = memwait | i_stall.
    - stallM = memwait.
    - flushW = memwait (bubble).
    - stallW = 0.
    - All other flushes 0.
- Reset: cnt=0, pend=0, pc_q=0. While rst is high: all flushes=1, all stalls=0, redirect=0, newpc=0, div_busyE=0, div_doneE=0.

## Timing
- All forwards, stalls and flushes are combinational from same-cycle inputs.
- Divider: div_startE in cycle t gives div_doneE in cycle t+DIV_CYCLES-1. div_busyE is high for cycles t..t+DIV_CYCLES-1.
- Redirect: a redirect pending across k i_stall cycles stays asserted with a constant newpc for k+1 cycles. It deasserts the cycle after i_stall falls.
- Simultaneous events:
  - exc during div_busyE aborts the divide: busy=0 next cycle, no done pulse.
  - A new exc while pend is set overwrites pc_q.
  - rst during pend or a divide clears it next edge.

## Configuration
- HAZARD_BRANCH_FWD_EN defined:
  - D forwarding: E match & !memtoregE → 10; else M match & !memtoregM → 01.
  - brstall = branchD & memtoregM & match(writeregM, rsD|rtD).
- Undefined:
  - forwardaD = forwardbD = 00.
  - brstall = branchD & (match E | match M) on rsD or rtD.

## Test plan
- Load-use: memtoregE=1, writeregE=8, rsD=8 → stallF=stallD=flushE=1 for one cycle; rsE=8 next cycle with M match → forwardaE=10.
- Divider, DIV_CYCLES=34: div_startE pulse at t → div_busyE high t..t+33, div_doneE only at t+33, stallM=flushW=1 throughout; second start at t+5 ignored.
- Exception under i_stall: excepttypeW=1 with i_stall=1 for 3 cycles → redirect high 4 cycles, newpc=BFC00380 throughout, flushD=1 each pending cycle.
- eret: excepttypeW=0000000E, cp0_epcW=BFC00100, i_stall=0 → newpc=BFC00100, all flushes 1, redirect low next cycle.
- Exception mid-divide at t+10 → div_busyE=0 at t+11, no div_doneE.
- Branch, macro on: branchD, rsD=4, writeregE=4, regwriteE=1 → forwardaD=10, no stall; macro off → stallF=stallD=flushE=1.
